// File: rtl/vgachargen_pkg.sv
// rtl/vgachargen_pkg.sv - shared character-memory sizes and fill FSM state type
package vgachargen_pkg;

  localparam int NUM_CHARS_DEF = 2400;
  localparam int ADDR_W_DEF    = 12;
  localparam int CHAR_W_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, req/gnt bit 0 = host, bit 1 = fill
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // set when the fill side took the most recent grant; host wins the next tie
  logic last_fill;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_fill ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_fill <= 1'b1;
    end else if (gnt[0]) begin
      last_fill <= 1'b0;
    end else if (gnt[1]) begin
      last_fill <= 1'b1;
    end
  end

endmodule

// File: rtl/charmem_wr_arb.sv
// rtl/charmem_wr_arb.sv - arbitrates host writes and a block-fill engine onto one character-memory write port
module charmem_wr_arb
  import vgachargen_pkg::*;
#(
  parameter int NUM_CHARS = NUM_CHARS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int CHAR_W    = CHAR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_req_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [CHAR_W-1:0] host_char_i,
  output logic              host_gnt_o,
  output logic              host_err_o,
  input  logic              fill_start_i,
  input  logic [ADDR_W-1:0] fill_base_i,
  input  logic [ADDR_W-1:0] fill_len_i,
  input  logic [CHAR_W-1:0] fill_char_i,
  input  logic              fill_abort_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [CHAR_W-1:0] mem_char_o,
  output logic              mem_wen_o
);

  localparam logic [ADDR_W:0] NUM_CHARS_W = (ADDR_W+1)'(NUM_CHARS);

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, cnt_q, ptr_nxt;
  logic [ADDR_W:0]   ptr_inc;
  logic [CHAR_W-1:0] fchar_q;
  logic [1:0]        gnt;
  logic              host_req, fill_req, host_oor, last_write;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CHAR_W-1:0] char_q;

  // abort masks the fill request so it can never win the same-cycle grant
  assign host_req   = rst_n && host_req_i;
  assign fill_req   = rst_n && (state_q == ST_FILL) && !fill_abort_i;
  assign host_oor   = {1'b0, host_addr_i} >= NUM_CHARS_W;
  assign ptr_inc    = {1'b0, ptr_q} + (ADDR_W+1)'(1);
  assign ptr_nxt    = (ptr_inc >= NUM_CHARS_W) ? '0 : ptr_inc[ADDR_W-1:0];
  assign last_write = gnt[1] && (cnt_q == ADDR_W'(1));

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({fill_req, host_req}),
    .gnt   (gnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fill_start_i) state_d = (fill_len_i != '0) ? ST_FILL : ST_DONE;
      ST_FILL: begin
        if (fill_abort_i)    state_d = ST_IDLE;
        else if (last_write) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fill_busy_o = rst_n && (state_q != ST_IDLE);
    fill_done_o = rst_n && (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      fchar_q <= '0;
    end else if ((state_q == ST_IDLE) && fill_start_i) begin
      ptr_q   <= fill_base_i;
      cnt_q   <= fill_len_i;
      fchar_q <= fill_char_i;
    end else if (gnt[1]) begin
      ptr_q   <= ptr_nxt;
      cnt_q   <= cnt_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      char_q <= '0;
    end else begin
      wen_q <= 1'b0;
      if (gnt[0] && !host_oor) begin
        wen_q  <= 1'b1;
        addr_q <= host_addr_i;
        char_q <= host_char_i;
      end else if (gnt[1]) begin
        wen_q  <= 1'b1;
        addr_q <= ptr_q;
        char_q <= fchar_q;
      end
    end
  end

  // registered port is also forced low while reset is held
  assign host_gnt_o = gnt[0];
  assign host_err_o = gnt[0] && host_oor;
  assign mem_wen_o  = rst_n && wen_q;
  assign mem_addr_o = rst_n ? addr_q : '0;
  assign mem_char_o = rst_n ? char_q : '0;

endmodule

// File: tb/tb_charmem_wr_arb.sv
// tb/tb_charmem_wr_arb.sv - scoreboard bench for charmem_wr_arb
module tb_charmem_wr_arb;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  c;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_req_i;
  logic [11:0] host_addr_i;
  logic [7:0]  host_char_i;
  logic        host_gnt_o, host_err_o;
  logic        fill_start_i;
  logic [11:0] fill_base_i, fill_len_i;
  logic [7:0]  fill_char_i;
  logic        fill_abort_i;
  logic        fill_busy_o, fill_done_o;
  logic [11:0] mem_addr_o;
  logic [7:0]  mem_char_o;
  logic        mem_wen_o;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad = 0;
  int  done_cnt = 0;
  int  done_base;
  int  w;

  int exp_busy[6] = '{1, 1, 1, 1, 1, 0};
  int exp_done[6] = '{0, 0, 0, 0, 1, 0};
  int exp_wen[6]  = '{0, 1, 1, 1, 1, 0};

  charmem_wr_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_req_i   (host_req_i),
    .host_addr_i  (host_addr_i),
    .host_char_i  (host_char_i),
    .host_gnt_o   (host_gnt_o),
    .host_err_o   (host_err_o),
    .fill_start_i (fill_start_i),
    .fill_base_i  (fill_base_i),
    .fill_len_i   (fill_len_i),
    .fill_char_i  (fill_char_i),
    .fill_abort_i (fill_abort_i),
    .fill_busy_o  (fill_busy_o),
    .fill_done_o  (fill_done_o),
    .mem_addr_o   (mem_addr_o),
    .mem_char_o   (mem_char_o),
    .mem_wen_o    (mem_wen_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [7:0] c);
    exp_q.push_back({a, c});
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    host_req_i = 1'b1; host_addr_i = 12'd3; host_char_i = 8'h09;
    fill_start_i = 1'b1; fill_base_i = 12'd0; fill_len_i = 12'd5; fill_char_i = 8'h01;
    fill_abort_i = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (fill_done_o) done_cnt++;
        if (mem_wen_o) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%0d char=%0h, expected no write", mem_addr_o, mem_char_o);
          end else begin
            mon_e = exp_q.pop_front();
            chk("write_addr", int'(mem_addr_o), int'(mon_e.a));
            chk("write_char", int'(mem_char_o), int'(mon_e.c));
          end
        end
      end
    join_none

    // reset held with active inputs: every output must stay low
    idle_cycles(3);
    @(negedge clk);
    chk("rst_gnt", host_gnt_o, 0);
    chk("rst_err", host_err_o, 0);
    chk("rst_busy", fill_busy_o, 0);
    chk("rst_done", fill_done_o, 0);
    chk("rst_wen", mem_wen_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_char", mem_char_o, 0);
    step();
    rst_n = 1'b1; host_req_i = 1'b0; fill_start_i = 1'b0;
    step();

    // single host write
    host_req_i = 1'b1; host_addr_i = 12'd5; host_char_i = 8'h41;
    push_wr(12'd5, 8'h41);
    @(negedge clk);
    chk("host_gnt", host_gnt_o, 1);
    chk("host_err_inrange", host_err_o, 0);
    step();
    host_req_i = 1'b0;
    @(negedge clk);
    chk("host_wen", mem_wen_o, 1);
    chk("host_addr", mem_addr_o, 5);
    chk("host_char", mem_char_o, 'h41);

    // out-of-range host write
    step();
    host_req_i = 1'b1; host_addr_i = 12'd2400; host_char_i = 8'h55;
    @(negedge clk);
    chk("oor_gnt", host_gnt_o, 1);
    chk("oor_err", host_err_o, 1);
    step();
    host_req_i = 1'b0;
    @(negedge clk);
    chk("oor_wen", mem_wen_o, 0);
    chk("oor_addr_hold", mem_addr_o, 5);

    // fill wrapping across the last cell
    step();
    done_base = done_cnt;
    fill_start_i = 1'b1; fill_base_i = 12'd2398; fill_len_i = 12'd4; fill_char_i = 8'h20;
    push_wr(12'd2398, 8'h20); push_wr(12'd2399, 8'h20);
    push_wr(12'd0, 8'h20);    push_wr(12'd1, 8'h20);
    @(negedge clk);
    chk("wrap_busy_c0", fill_busy_o, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      fill_start_i = 1'b0;
      @(negedge clk);
      chk("wrap_busy", fill_busy_o, exp_busy[i]);
      chk("wrap_done", fill_done_o, exp_done[i]);
      chk("wrap_wen", mem_wen_o, exp_wen[i]);
    end
    chk("wrap_q_empty", exp_q.size(), 0);
    chk("wrap_done_cnt", done_cnt - done_base, 1);

    // zero-length fill
    step();
    done_base = done_cnt;
    fill_start_i = 1'b1; fill_base_i = 12'd7; fill_len_i = 12'd0; fill_char_i = 8'h11;
    step();
    fill_start_i = 1'b0;
    @(negedge clk);
    chk("len0_done", fill_done_o, 1);
    chk("len0_busy", fill_busy_o, 1);
    chk("len0_wen", mem_wen_o, 0);
    step();
    @(negedge clk);
    chk("len0_done_end", fill_done_o, 0);
    chk("len0_busy_end", fill_busy_o, 0);
    chk("len0_done_cnt", done_cnt - done_base, 1);

    // start while busy is ignored
    step();
    done_base = done_cnt;
    fill_start_i = 1'b1; fill_base_i = 12'd10; fill_len_i = 12'd3; fill_char_i = 8'h33;
    push_wr(12'd10, 8'h33); push_wr(12'd11, 8'h33); push_wr(12'd12, 8'h33);
    step();
    fill_start_i = 1'b0;
    step();
    fill_start_i = 1'b1; fill_base_i = 12'd50; fill_len_i = 12'd5; fill_char_i = 8'h77;
    step();
    fill_start_i = 1'b0;
    step();
    fill_start_i = 1'b1;
    step();
    fill_start_i = 1'b0;
    idle_cycles(4);
    chk("busy_start_q_empty", exp_q.size(), 0);
    chk("busy_start_done_cnt", done_cnt - done_base, 1);
    chk("busy_start_idle", fill_busy_o, 0);

    // contention: host held continuously against a 10-cell fill
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    done_base = done_cnt;
    for (int k = 0; k < 10; k++) begin
      push_wr(12'(100 + k), 8'(8'h60 + k));
      push_wr(12'(k), 8'h2A);
    end
    push_wr(12'd110, 8'h6A);
    fill_start_i = 1'b1; fill_base_i = 12'd0; fill_len_i = 12'd10; fill_char_i = 8'h2A;
    host_req_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      host_addr_i = 12'(100 + i);
      host_char_i = 8'(8'h60 + i);
      w = 0;
      @(negedge clk);
      while (!host_gnt_o && w < 4) begin
        step();
        fill_start_i = 1'b0;
        w++;
        @(negedge clk);
      end
      chk("rr_host_gnt", host_gnt_o, 1);
      chk("rr_host_wait", w, (i == 0) ? 0 : 1);
      step();
      fill_start_i = 1'b0;
    end
    host_req_i = 1'b0;
    idle_cycles(3);
    chk("rr_q_empty", exp_q.size(), 0);
    chk("rr_done_cnt", done_cnt - done_base, 1);
    chk("rr_idle", fill_busy_o, 0);

    // abort on the third fill cycle
    step();
    done_base = done_cnt;
    fill_start_i = 1'b1; fill_base_i = 12'd20; fill_len_i = 12'd8; fill_char_i = 8'h44;
    push_wr(12'd20, 8'h44); push_wr(12'd21, 8'h44);
    step();
    fill_start_i = 1'b0;
    step();
    step();
    fill_abort_i = 1'b1;
    @(negedge clk);
    chk("abort_busy_c3", fill_busy_o, 1);
    step();
    fill_abort_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", fill_busy_o, 0);
    chk("abort_done", fill_done_o, 0);
    chk("abort_wen", mem_wen_o, 0);
    idle_cycles(4);
    chk("abort_q_empty", exp_q.size(), 0);
    chk("abort_done_cnt", done_cnt - done_base, 0);

    // reset in the middle of a fill
    step();
    done_base = done_cnt;
    fill_start_i = 1'b1; fill_base_i = 12'd30; fill_len_i = 12'd8; fill_char_i = 8'h66;
    push_wr(12'd30, 8'h66);
    step();
    fill_start_i = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    host_req_i = 1'b1; host_addr_i = 12'd3; host_char_i = 8'h09;
    @(negedge clk);
    chk("midrst_wen", mem_wen_o, 0);
    chk("midrst_gnt", host_gnt_o, 0);
    chk("midrst_busy", fill_busy_o, 0);
    chk("midrst_addr", mem_addr_o, 0);
    step();
    rst_n = 1'b1;
    host_req_i = 1'b0;
    @(negedge clk);
    chk("midrst_busy_after", fill_busy_o, 0);
    chk("midrst_done_after", fill_done_o, 0);
    idle_cycles(4);
    chk("midrst_q_empty", exp_q.size(), 0);
    chk("midrst_done_cnt", done_cnt - done_base, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
